// File: rtl/sobel_stage_scheduler.sv
// Row/column/phase scheduler for the Sobel datapath: stage-enable pulses,
// per-word SRAM1 address and a one-shot refill request per frame.
module sobel_stage_scheduler #(
    parameter int IMG_WORDS    = 64,
    parameter int IMG_ROWS     = 512,
    parameter int PREFETCH_ROW = 410
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startEn,
    input  logic        stallIn,
    input  logic        nextAck,
    output logic [19:0] read_addr,
    output logic        popBufferEn,
    output logic        sobelShiftEn,
    output logic        HoldEn,
    output logic        startMultiplierEn,
    output logic        startMagEn,
    output logic        startDirEn,
    output logic        getNext,
    output logic        busy,
    output logic        frameDone
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [9:0] COL_LAST = 10'(IMG_WORDS - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_ROWS - 2);
    localparam logic [9:0] PF_ROW   = 10'(PREFETCH_ROW);

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [9:0]  col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic [19:0] addr_q, addr_d;
    logic        issued_q, issued_d;
    logic        pend_q, pend_d;
    logic        active;
    logic        last_word;
    logic        set_req;
    logic        get_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            phase_q  <= 2'd0;
            col_q    <= 10'd0;
            row_q    <= 10'd0;
            addr_q   <= 20'd0;
            issued_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            col_q    <= col_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        col_d     = col_q;
        row_d     = row_q;
        issued_d  = issued_q;
        active    = (state_q == S_RUN) && !stallIn;
        last_word = (row_q == ROW_LAST) && (col_q == COL_LAST);
        // One request per frame; a request still pending blocks a re-issue.
        set_req   = active && (phase_q == 2'd0) && (row_q == PF_ROW)
                    && (col_q == 10'd0) && !issued_q && !pend_q;
        get_next  = pend_q || set_req;
        pend_d    = get_next && !nextAck;

        unique case (state_q)
            S_IDLE: begin
                if (startEn) begin
                    state_d  = S_RUN;
                    phase_d  = 2'd0;
                    col_d    = 10'd0;
                    row_d    = 10'd0;
                    issued_d = 1'b0;
                end
            end
            S_RUN: begin
                if (set_req) begin
                    issued_d = 1'b1;
                end
                if (active) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        if (last_word) begin
                            state_d = S_DONE;
                            col_d   = 10'd0;
                            row_d   = 10'd0;
                        end else if (col_q == COL_LAST) begin
                            col_d = 10'd0;
                            row_d = row_q + 10'd2;
                        end else begin
                            col_d = col_q + 10'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        addr_d = 20'(row_d) * 20'(IMG_WORDS) + 20'(col_d);
    end

    assign read_addr         = addr_q;
    assign popBufferEn       = active && (phase_q == 2'd0);
    assign sobelShiftEn      = active && (phase_q == 2'd1);
    assign HoldEn            = active && (phase_q == 2'd2);
    assign startMultiplierEn = active && (phase_q == 2'd2);
    assign startMagEn        = active && (phase_q == 2'd3);
    assign startDirEn        = active && (phase_q == 2'd3);
    assign getNext           = get_next;
    assign busy              = (state_q == S_RUN) || (state_q == S_DONE);
    assign frameDone         = (state_q == S_DONE);

endmodule
